// File: rtl/shift_deserializer_if.sv
// Handshake and data bundle for shift_deserializer.
// The master side drives the serial stream and consumes q; the slave side is the deserializer.
interface shift_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic             dir;
    logic             cont;
    logic             sin;
    logic             sin_valid;
    logic             sin_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             busy;
    logic [3:0]       bit_cnt;
    logic             perr;

    modport master (
        output start, abort, dir, cont, sin, sin_valid, q_ready,
        input  sin_ready, q, q_valid, busy, bit_cnt, perr
    );

    modport slave (
        input  start, abort, dir, cont, sin, sin_valid, q_ready,
        output sin_ready, q, q_valid, busy, bit_cnt, perr
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with LSB/MSB-first order, single/continuous mode and output backpressure.
// Optional feature macro: PARITY_CHECK_EN adds a 9th even-parity bit per word and drives perr.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_deserializer_if.slave  bus
);

`ifdef PARITY_CHECK_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state, nxt_state;
    logic [WIDTH-1:0] shreg, nxt_shreg, shifted, word, q_r;
    logic [3:0]       cnt, nxt_cnt;
    logic             dir_r, cont_r;
    logic             sin_ready_r, busy_r, q_valid_r;
    logic             accept, transfer, out_free, last_bit, load;

`ifdef PARITY_CHECK_EN
    logic             perr_r, pend_perr, nxt_pend_perr, word_perr, bit_perr;
    assign bit_perr = (^shreg) ^ bus.sin;
`endif

    assign accept   = bus.sin_valid & sin_ready_r;
    assign transfer = q_valid_r & bus.q_ready;
    assign out_free = ~q_valid_r | bus.q_ready;
    assign last_bit = (cnt == 4'(N - 1));
    assign shifted  = dir_r ? {shreg[WIDTH-2:0], bus.sin} : {bus.sin, shreg[WIDTH-1:1]};

    always_comb begin
        nxt_state = state;
        nxt_shreg = shreg;
        nxt_cnt   = cnt;
        load      = 1'b0;
        word      = shreg;
`ifdef PARITY_CHECK_EN
        nxt_pend_perr = pend_perr;
        word_perr     = pend_perr;
`endif
        if (bus.abort) begin
            nxt_state = IDLE;
            nxt_shreg = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        nxt_state = SHIFT;
                        nxt_cnt   = '0;
                        nxt_shreg = '0;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        if (last_bit) begin
                            // The parity bit is checked but never shifted into the data word.
`ifdef PARITY_CHECK_EN
                            word      = shreg;
                            word_perr = bit_perr;
`else
                            word      = shifted;
`endif
                            if (out_free) begin
                                load      = 1'b1;
                                nxt_cnt   = '0;
                                nxt_shreg = '0;
                                nxt_state = cont_r ? SHIFT : IDLE;
                            end else begin
                                nxt_state = HOLD;
                                nxt_cnt   = cnt + 4'd1;
                                nxt_shreg = word;
`ifdef PARITY_CHECK_EN
                                nxt_pend_perr = bit_perr;
`endif
                            end
                        end else begin
                            nxt_shreg = shifted;
                            nxt_cnt   = cnt + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        load      = 1'b1;
                        nxt_cnt   = '0;
                        nxt_shreg = '0;
                        nxt_state = cont_r ? SHIFT : IDLE;
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            dir_r       <= 1'b0;
            cont_r      <= 1'b0;
            sin_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            q_r         <= '0;
            q_valid_r   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_r      <= 1'b0;
            pend_perr   <= 1'b0;
`endif
        end else begin
            state       <= nxt_state;
            shreg       <= nxt_shreg;
            cnt         <= nxt_cnt;
            sin_ready_r <= (nxt_state == SHIFT);
            busy_r      <= (nxt_state != IDLE);
            if (state == IDLE && bus.start && !bus.abort) begin
                dir_r  <= bus.dir;
                cont_r <= bus.cont;
            end
            // A load on the same edge as a transfer keeps q_valid high with the new word.
            if (load) begin
                q_r       <= word;
                q_valid_r <= 1'b1;
`ifdef PARITY_CHECK_EN
                perr_r    <= word_perr;
`endif
            end else if (transfer) begin
                q_valid_r <= 1'b0;
            end
`ifdef PARITY_CHECK_EN
            pend_perr <= nxt_pend_perr;
`endif
        end
    end

    assign bus.sin_ready = sin_ready_r;
    assign bus.busy      = busy_r;
    assign bus.q         = q_r;
    assign bus.q_valid   = q_valid_r;
    assign bus.bit_cnt   = cnt;
`ifdef PARITY_CHECK_EN
    assign bus.perr      = perr_r;
`else
    assign bus.perr      = 1'b0;
`endif

endmodule
